// File: rtl/btb_update_queue.sv
// btb_update_queue: writer side of the branch target buffer.
// Buffers resolved taken branches (PC, target) in a small FIFO and drains at
// most one entry per cycle into the single BTB write port. An empty queue with
// no hold forwards the incoming pair straight to the output registers.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   resolve_*_in         resolved branch from the resolve/commit stage
//   drain_hold_in        1 = nothing leaves the queue this cycle
//   btb_write_*_out      registered BTB write strobe / target (NPC) / branch PC (dest)
//   queue_full_out       registered count == QDEPTH
//   queue_empty_out      registered count == 0
//   drop_count_out       saturating count of pushes lost to a full queue
//
// Optional feature macro: BTBQ_COALESCE_EN -- a push whose PC matches the most
// recently stored entry (not being popped) overwrites that entry's target.
module btb_update_queue #(
   parameter int unsigned QDEPTH    = 4,
   parameter int unsigned QPTR_BITS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        resolve_valid_in,
   input  logic        resolve_taken_in,
   input  logic [63:0] resolve_PC_in,
   input  logic [63:0] resolve_target_in,
   input  logic        drain_hold_in,
   output logic        btb_write_out,
   output logic [63:0] btb_write_NPC_out,
   output logic [63:0] btb_write_dest_out,
   output logic        queue_full_out,
   output logic        queue_empty_out,
   output logic [15:0] drop_count_out
);

   localparam logic [QPTR_BITS:0] CntFull = (QPTR_BITS + 1)'(QDEPTH);

   logic [QPTR_BITS:0]   count_q, count_d;
   logic [QPTR_BITS-1:0] head_q, head_d;
   logic [QPTR_BITS-1:0] tail_q, tail_d;
   logic [63:0]          mem_pc_q  [QDEPTH];
   logic [63:0]          mem_pc_d  [QDEPTH];
   logic [63:0]          mem_tgt_q [QDEPTH];
   logic [63:0]          mem_tgt_d [QDEPTH];
   logic                 write_q, write_d;
   logic [63:0]          npc_q, npc_d;
   logic [63:0]          dest_q, dest_d;
   logic [15:0]          drop_q, drop_d;

   logic push, pop, bypass, coalesce, store, drop;

`ifdef BTBQ_COALESCE_EN
   logic [QPTR_BITS-1:0] tail_prev;
   assign tail_prev = tail_q - QPTR_BITS'(1);
   // When count == 1 and popping, tail-1 is the head leaving this cycle.
   assign coalesce  = push && (count_q != '0) && (mem_pc_q[tail_prev] == resolve_PC_in) &&
                      !(pop && (count_q == (QPTR_BITS + 1)'(1)));
`else
   assign coalesce  = 1'b0;
`endif

   always_comb begin
      push   = resolve_valid_in & resolve_taken_in;
      pop    = (count_q != '0) & ~drain_hold_in;
      bypass = (count_q == '0) & push & ~drain_hold_in;
      store  = push & ~bypass & ~coalesce & ((count_q < CntFull) | pop);
      drop   = push & ~bypass & ~coalesce & ~store;

      count_d   = count_q;
      head_d    = head_q;
      tail_d    = tail_q;
      mem_pc_d  = mem_pc_q;
      mem_tgt_d = mem_tgt_q;
      write_d   = 1'b0;
      npc_d     = npc_q;
      dest_d    = dest_q;
      drop_d    = drop_q;

      if (pop) begin
         write_d = 1'b1;
         npc_d   = mem_tgt_q[head_q];
         dest_d  = mem_pc_q[head_q];
         head_d  = head_q + QPTR_BITS'(1);
      end else if (bypass) begin
         write_d = 1'b1;
         npc_d   = resolve_target_in;
         dest_d  = resolve_PC_in;
      end

      if (store) begin
         mem_pc_d[tail_q]  = resolve_PC_in;
         mem_tgt_d[tail_q] = resolve_target_in;
         tail_d            = tail_q + QPTR_BITS'(1);
      end

`ifdef BTBQ_COALESCE_EN
      if (coalesce) begin
         mem_tgt_d[tail_prev] = resolve_target_in;
      end
`endif

      if (store && !pop) begin
         count_d = count_q + (QPTR_BITS + 1)'(1);
      end else if (!store && pop) begin
         count_d = count_q - (QPTR_BITS + 1)'(1);
      end

      if (drop && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         write_q <= 1'b0;
         npc_q   <= 64'd0;
         dest_q  <= 64'd0;
         drop_q  <= 16'd0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         write_q <= write_d;
         npc_q   <= npc_d;
         dest_q  <= dest_d;
         drop_q  <= drop_d;
      end
   end

   // Entry storage is not reset; pointers and count make stale data unreachable.
   always_ff @(posedge clock) begin
      mem_pc_q  <= mem_pc_d;
      mem_tgt_q <= mem_tgt_d;
   end

   assign btb_write_out      = write_q;
   assign btb_write_NPC_out  = npc_q;
   assign btb_write_dest_out = dest_q;
   assign queue_full_out     = (count_q == CntFull);
   assign queue_empty_out    = (count_q == '0);
   assign drop_count_out     = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed self-checking bench for btb_update_queue.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_btb_update_queue;

   logic        clock;
   logic        reset;
   logic        resolve_valid_in;
   logic        resolve_taken_in;
   logic [63:0] resolve_PC_in;
   logic [63:0] resolve_target_in;
   logic        drain_hold_in;
   logic        btb_write_out;
   logic [63:0] btb_write_NPC_out;
   logic [63:0] btb_write_dest_out;
   logic        queue_full_out;
   logic        queue_empty_out;
   logic [15:0] drop_count_out;

   int checks = 0;
   int errors = 0;

   btb_update_queue #(.QDEPTH(4), .QPTR_BITS(2)) dut (
      .clock              (clock),
      .reset              (reset),
      .resolve_valid_in   (resolve_valid_in),
      .resolve_taken_in   (resolve_taken_in),
      .resolve_PC_in      (resolve_PC_in),
      .resolve_target_in  (resolve_target_in),
      .drain_hold_in      (drain_hold_in),
      .btb_write_out      (btb_write_out),
      .btb_write_NPC_out  (btb_write_NPC_out),
      .btb_write_dest_out (btb_write_dest_out),
      .queue_full_out     (queue_full_out),
      .queue_empty_out    (queue_empty_out),
      .drop_count_out     (drop_count_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic t, input logic [63:0] pc,
                        input logic [63:0] tgt, input logic hold);
      resolve_valid_in  = v;
      resolve_taken_in  = t;
      resolve_PC_in     = pc;
      resolve_target_in = tgt;
      drain_hold_in     = hold;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      tick();
      tick();
      checks++;
      if (btb_write_out !== 1'b0 || btb_write_NPC_out !== 64'd0 || btb_write_dest_out !== 64'd0) begin
         errors++;
         $display("FAIL reset_outputs: write=%b npc=%h dest=%h required 0/0/0",
                  btb_write_out, btb_write_NPC_out, btb_write_dest_out);
      end
      checks++;
      if (queue_empty_out !== 1'b1 || queue_full_out !== 1'b0 || drop_count_out !== 16'd0) begin
         errors++;
         $display("FAIL reset_flags: empty=%b full=%b drop=%h required 1/0/0000",
                  queue_empty_out, queue_full_out, drop_count_out);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b1, 1'b1, 64'h100, 64'h200, 1'b0);
      tick();
      drive(1'b1, 1'b1, 64'h108, 64'h300, 1'b0);
      checks++;
      if (btb_write_out !== 1'b1 || btb_write_NPC_out !== 64'h200 ||
          btb_write_dest_out !== 64'h100 || queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL bypass_first: write=%b npc=%h dest=%h empty=%b required 1/200/100/1",
                  btb_write_out, btb_write_NPC_out, btb_write_dest_out, queue_empty_out);
      end
      tick();
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      checks++;
      if (btb_write_out !== 1'b1 || btb_write_NPC_out !== 64'h300 ||
          btb_write_dest_out !== 64'h108 || queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL bypass_b2b: write=%b npc=%h dest=%h empty=%b required 1/300/108/1",
                  btb_write_out, btb_write_NPC_out, btb_write_dest_out, queue_empty_out);
      end
      tick();
      checks++;
      if (btb_write_out !== 1'b0 || btb_write_NPC_out !== 64'h300 || btb_write_dest_out !== 64'h108) begin
         errors++;
         $display("FAIL idle_hold_outputs: write=%b npc=%h dest=%h required 0/300/108",
                  btb_write_out, btb_write_NPC_out, btb_write_dest_out);
      end
   endtask

   task automatic fill_four();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 64'(i * 16), 64'(i * 16 + 64'h1000), 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
   endtask

   task automatic test_fill_drain();
      fill_four();
      checks++;
      if (queue_full_out !== 1'b1 || btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: full=%b write=%b required 1/0", queue_full_out, btb_write_out);
      end
      drain_hold_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'(i * 16) ||
             btb_write_NPC_out !== 64'(i * 16 + 64'h1000)) begin
            errors++;
            $display("FAIL drain_order_%0d: write=%b dest=%h npc=%h required 1/%h/%h", i,
                     btb_write_out, btb_write_dest_out, btb_write_NPC_out,
                     64'(i * 16), 64'(i * 16 + 64'h1000));
         end
      end
      checks++;
      if (queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL drain_empty: empty=%b required 1", queue_empty_out);
      end
      tick();
      checks++;
      if (btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL drain_idle: write=%b required 0", btb_write_out);
      end
   endtask

   task automatic test_drop();
      fill_four();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 64'h900 + 64'(i), 64'h990, 1'b1);
         tick();
      end
      checks++;
      if (drop_count_out !== 16'd3 || queue_full_out !== 1'b1 || btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL drop_three: drop=%h full=%b write=%b required 0003/1/0",
                  drop_count_out, queue_full_out, btb_write_out);
      end
      // Walk the counter up to its ceiling, then push once more.
      for (int i = 0; i < 65532; i++) tick();
      checks++;
      if (drop_count_out !== 16'hFFFF) begin
         errors++;
         $display("FAIL drop_reach_max: drop=%h required ffff", drop_count_out);
      end
      tick();
      checks++;
      if (drop_count_out !== 16'hFFFF) begin
         errors++;
         $display("FAIL drop_saturate: drop=%h required ffff", drop_count_out);
      end
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1);
   endtask

   task automatic test_back_to_back();
      // Queue still holds 0x10..0x40 from the drop test; push while full and draining.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 64'hA0 + 64'(i * 16), 64'hB00 + 64'(i), 1'b0);
         tick();
         checks++;
         if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'(i * 16) ||
             queue_full_out !== 1'b1 || drop_count_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL full_pushpop_%0d: write=%b dest=%h full=%b drop=%h required 1/%h/1/ffff",
                     i, btb_write_out, btb_write_dest_out, queue_full_out, drop_count_out,
                     64'(i * 16));
         end
      end
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'hA0 + 64'(i * 16) ||
             btb_write_NPC_out !== 64'hB00 + 64'(i)) begin
            errors++;
            $display("FAIL pushpop_drain_%0d: write=%b dest=%h npc=%h required 1/%h/%h", i,
                     btb_write_out, btb_write_dest_out, btb_write_NPC_out,
                     64'hA0 + 64'(i * 16), 64'hB00 + 64'(i));
         end
      end
      tick();
      checks++;
      if (queue_empty_out !== 1'b1 || btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_end: empty=%b write=%b required 1/0", queue_empty_out, btb_write_out);
      end
   endtask

   task automatic test_not_taken_and_reset();
      drive(1'b1, 1'b0, 64'h50, 64'h55, 1'b1);
      tick();
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      checks++;
      if (queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL not_taken_ignored: empty=%b required 1", queue_empty_out);
      end
      tick();
      checks++;
      if (btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL not_taken_nowrite: write=%b required 0", btb_write_out);
      end
      drive(1'b1, 1'b1, 64'h500, 64'h600, 1'b1);
      tick();
      drive(1'b1, 1'b1, 64'h510, 64'h610, 1'b1);
      tick();
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (btb_write_out !== 1'b0 || queue_empty_out !== 1'b1 || drop_count_out !== 16'd0) begin
         errors++;
         $display("FAIL reset_middrain: write=%b empty=%b drop=%h required 0/1/0000",
                  btb_write_out, queue_empty_out, drop_count_out);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (btb_write_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_nowrite_%0d: write=%b required 0", i, btb_write_out);
         end
      end
   endtask

   task automatic test_coalesce();
      drive(1'b1, 1'b1, 64'h60, 64'h70, 1'b1);
      tick();
      drive(1'b1, 1'b1, 64'h60, 64'h80, 1'b1);
      tick();
      drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      checks++;
      if (queue_empty_out !== 1'b0 || queue_full_out !== 1'b0) begin
         errors++;
         $display("FAIL coal_count: empty=%b full=%b required 0/0", queue_empty_out, queue_full_out);
      end
      tick();
`ifdef BTBQ_COALESCE_EN
      checks++;
      if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'h60 || btb_write_NPC_out !== 64'h80 ||
          queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL coal_single: write=%b dest=%h npc=%h empty=%b required 1/60/80/1",
                  btb_write_out, btb_write_dest_out, btb_write_NPC_out, queue_empty_out);
      end
      tick();
      checks++;
      if (btb_write_out !== 1'b0) begin
         errors++;
         $display("FAIL coal_no_second: write=%b required 0", btb_write_out);
      end
`else
      checks++;
      if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'h60 || btb_write_NPC_out !== 64'h70 ||
          queue_empty_out !== 1'b0) begin
         errors++;
         $display("FAIL dup_first: write=%b dest=%h npc=%h empty=%b required 1/60/70/0",
                  btb_write_out, btb_write_dest_out, btb_write_NPC_out, queue_empty_out);
      end
      tick();
      checks++;
      if (btb_write_out !== 1'b1 || btb_write_dest_out !== 64'h60 || btb_write_NPC_out !== 64'h80 ||
          queue_empty_out !== 1'b1) begin
         errors++;
         $display("FAIL dup_second: write=%b dest=%h npc=%h empty=%b required 1/60/80/1",
                  btb_write_out, btb_write_dest_out, btb_write_NPC_out, queue_empty_out);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_fill_drain();
      test_drop();
      test_back_to_back();
      test_not_taken_and_reset();
      test_coalesce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
